ext_field_pipe: RTL and testbench
=================================

# ext_field_pipe

Parametrised, registered LC-3 immediate-field extractor. Accepts a 16-bit instruction word plus a field selector over a valid/ready handshake. Extracts the selected immediate/offset field, sign- or zero-extends it to OUT_W bits, and queues the result in a small output FIFO. It sits between the IR and the datapath address/ALU adders. It replaces the four fixed-width combinational extenders with one block that supports back-pressure and field/mode selection.

## Interface
- OUT_W, default 16: result width; legal range 11..32.
- DEPTH, default 2: output FIFO entries; power of two, ≥2.
- Clk  in  1: clock; all state changes on its rising edge.
- Reset_n  in  1: reset, asynchronous and active-low.
- in_valid  in  1: instr/sel are valid this cycle.
- in_ready  out  1: block can accept; equals (level != DEPTH).
- instr  in  16: instruction word.
- sel  in  3: field select. Encodings:
  - 0 = IR[4:0] sext
  - 1 = IR[5:0] sext
  - 2 = IR[8:0] sext
  - 3 = IR[10:0] sext
  - 4 = IR[7:0] zext (trapvect8)
  - 5 = IR[4:0] zext
  - 6, 7 = illegal
- out_valid  out  1: FIFO head holds a result.
- out_ready  in  1: consumer takes head this cycle.
- out_data  out  OUT_W: extended value at FIFO head.
- out_sel  out  3: sel that produced the head entry.
- out_err  out  1: head entry came from an illegal sel.
- level  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push: occurs when in_valid && in_ready. The extended value, sel and err are written to the tail entry.
- Sign extension: replicate the field MSB into bits OUT_W-1 down to the field width.
- Zero extension: fill the upper bits with 0.
- Illegal sel (6, 7): the entry is still accepted and consumes a slot. It is stored with data=0 and err=1.
- Pop: occurs when out_valid && out_ready. The head pointer advances.
- State: read pointer, write pointer (log2 DEPTH bits each, wrap modulo DEPTH) and level counter.
- Derived flags: empty = (level==0); full = (level==DEPTH).
- Level update:
  - Push and pop in the same cycle: level unchanged, both pointers advance. Legal whenever 0 < level < DEPTH.
  - Push only: level+1.
  - Pop only: level−1.
- When full, in_ready=0 and in_valid is ignored. There is no bypass, so a same-cycle pop does not open a slot until the next cycle.
- When empty, out_ready is ignored and the pointers do not move.
- Output signals:
  - out_valid = !empty.
  - out_data, out_sel, out_err = storage at the read pointer.
  - When empty, these outputs show the stale last-popped entry and the consumer must ignore them.
- Reset (asserted any time, including mid-transfer): pointers=0, level=0, all storage cleared to 0, and in-flight entries are discarded. Outputs while in reset are:
  - out_valid=0
  - in_ready=1
  - out_data=0, out_sel=0, out_err=0
  - level=0
- Release is synchronous to Clk. The first push can occur on the first rising edge after Reset_n goes high.

## Timing
- Latency: an entry pushed at edge N appears with out_valid=1 after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: 1 result/cycle while out_ready is held high.
- in_ready depends only on registered level. There is no combinational path from out_ready or in_valid to in_ready.
- No combinational path from instr or sel to any output: all outputs are registered or decoded from registered state.
- Extension logic is one level of muxing before the storage write and must close timing at the datapath clock.

## Test plan
- Reset release, then push instr=0x1025, sel=0 with out_ready=1: out_data=0x0005, out_err=0 one cycle later, level returns to 0.
- Sign extension, pushed back-to-back with out_ready=1:
  - 0x103F sel0 → 0xFFFF
  - 0x6FE0 sel1 → 0xFFE0
  - 0x0FFF sel2 → 0xFFFF
  - 0x4C00 sel3 → 0xFC00
  - Results emerge in order, one per cycle.
- Zero extension and errors:
  - 0xF025 sel4 → 0x0025
  - 0x103F sel5 → 0x001F
  - 0x1234 sel6 → out_data=0, out_err=1, out_sel=6
- Back-pressure, DEPTH=2: hold out_ready=0 and present 3 valid words.
  - The first two are accepted; level=2 and in_ready=0. The third is held.
  - Raise out_ready: the first two drain in order. The third is accepted the cycle after in_ready returns to 1.
- Simultaneous push/pop at level=1 for 8 cycles: level stays 1, pointers wrap, and data order is preserved.
- Assert Reset_n=0 asynchronously mid-cycle with level=2: out_valid drops immediately, level=0, in_ready=1, out_data=0. After release, a new push is unaffected by the discarded data.

Source files
------------

// File: rtl/ext_field_pipe_if.sv
// Handshake bundle for ext_field_pipe: instruction/selector in, extended field out.
// The slave modport is the extractor itself; master is the IR-side producer plus datapath consumer.
interface ext_field_pipe_if #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [15:0]              instr;
    logic [2:0]               sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic [2:0]               out_sel;
    logic                     out_err;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output in_valid, instr, sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_err, level
    );

    modport slave (
        input  in_valid, instr, sel, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_err, level
    );
endinterface

// File: rtl/ext_field_pipe.sv
// LC-3 immediate/offset field extractor: selects an IR field, sign/zero-extends it
// to OUT_W bits and queues the result in a DEPTH-entry FIFO with valid/ready on both sides.
module ext_field_pipe #(
    parameter int OUT_W = 16,
    parameter int DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    ext_field_pipe_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [2:0]       mem_sel  [DEPTH];
    logic             mem_err  [DEPTH];

    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [LW-1:0]    lvl;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    assign full  = (lvl == LW'(DEPTH));
    assign empty = (lvl == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = !empty && bus.out_ready;

    // Single mux level feeding the storage write port.
    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (bus.sel)
            3'd0:    ext_data = {{(OUT_W-5){bus.instr[4]}},  bus.instr[4:0]};
            3'd1:    ext_data = {{(OUT_W-6){bus.instr[5]}},  bus.instr[5:0]};
            3'd2:    ext_data = {{(OUT_W-9){bus.instr[8]}},  bus.instr[8:0]};
            3'd3:    ext_data = {{(OUT_W-11){bus.instr[10]}}, bus.instr[10:0]};
            3'd4:    ext_data = {{(OUT_W-8){1'b0}}, bus.instr[7:0]};
            3'd5:    ext_data = {{(OUT_W-5){1'b0}}, bus.instr[4:0]};
            default: ext_err  = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            lvl    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_sel[i]  <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= ext_data;
                mem_sel[wr_ptr]  <= bus.sel;
                mem_err[wr_ptr]  <= ext_err;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                lvl <= lvl + LW'(1);
            end else if (pop && !push) begin
                lvl <= lvl - LW'(1);
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_data[rd_ptr];
    assign bus.out_sel   = mem_sel[rd_ptr];
    assign bus.out_err   = mem_err[rd_ptr];
    assign bus.level     = lvl;
endmodule

// File: tb/tb_ext_field_pipe.sv
// Self-checking bench for ext_field_pipe: table-driven vectors through a scoreboard queue,
// plus hand-written back-pressure, steady push/pop and asynchronous-reset sequences.
module tb_ext_field_pipe;
    typedef struct {
        logic [15:0] instr;
        logic [2:0]  sel;
        logic [15:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  sel;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t q[$];
    vec_t vecs[14];

    ext_field_pipe_if #(.OUT_W(16), .DEPTH(2)) bus ();

    ext_field_pipe #(.OUT_W(16), .DEPTH(2)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Outputs are sampled on the falling edge, where a pop about to occur is already decided.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got data 0x%0h, expected no entry", bus.out_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_sel",  32'(bus.out_sel),  32'(e.sel));
                check("out_err",  32'(bus.out_err),  32'(e.err));
            end
        end
    end

    // Caller is 1 time unit after a rising edge; returns likewise after the accepting edge.
    task automatic send(input vec_t v);
        bit done;
        done = 1'b0;
        bus.instr    = v.instr;
        bus.sel      = v.sel;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            if (bus.in_ready) begin
                q.push_back('{data: v.data, sel: v.sel, err: v.err});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (q.size() == 0 && bus.level == 0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("drain_empty", 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_out_sel"},   32'(bus.out_sel),   32'd0);
        check({tag, "_out_err"},   32'(bus.out_err),   32'd0);
        check({tag, "_level"},     32'(bus.level),     32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{16'h1025, 3'd0, 16'h0005, 1'b0};
        vecs[1]  = '{16'h103F, 3'd0, 16'hFFFF, 1'b0};
        vecs[2]  = '{16'h6FE0, 3'd1, 16'hFFE0, 1'b0};
        vecs[3]  = '{16'h0FFF, 3'd2, 16'hFFFF, 1'b0};
        vecs[4]  = '{16'h4C00, 3'd3, 16'hFC00, 1'b0};
        vecs[5]  = '{16'hF025, 3'd4, 16'h0025, 1'b0};
        vecs[6]  = '{16'h103F, 3'd5, 16'h001F, 1'b0};
        vecs[7]  = '{16'h1234, 3'd6, 16'h0000, 1'b1};
        vecs[8]  = '{16'hFFFF, 3'd7, 16'h0000, 1'b1};
        vecs[9]  = '{16'h000F, 3'd0, 16'h000F, 1'b0};
        vecs[10] = '{16'hFF1F, 3'd1, 16'h001F, 1'b0};
        vecs[11] = '{16'h0100, 3'd2, 16'hFF00, 1'b0};
        vecs[12] = '{16'hFBFF, 3'd3, 16'h03FF, 1'b0};
        vecs[13] = '{16'h00F0, 3'd4, 16'h00F0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First push, then the result must be visible in the following cycle.
        bus.out_ready = 1'b1;
        send(vecs[0]);
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
        check("latency_level", 32'(bus.level), 32'd1);
        @(posedge clk);
        #1;
        check("level_back_to_0", 32'(bus.level), 32'd0);
        check("empty_out_valid", 32'(bus.out_valid), 32'd0);

        // Whole table back-to-back with out_ready high: one result per cycle.
        for (int i = 1; i < 14; i++) begin
            send(vecs[i]);
            check("streaming_in_ready", 32'(bus.in_ready), 32'd1);
        end
        drain();

        // Back-pressure: two accepted, third held until a slot frees.
        bus.out_ready = 1'b0;
        fork
            begin
                send(vecs[2]);
                send(vecs[5]);
                send(vecs[7]);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int n = 0; n < 20 && !seen; n++) begin
                    @(negedge clk);
                    if (bus.level == 2) seen = 1'b1;
                end
                check("bp_reached_full", 32'(seen), 32'd1);
                check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("bp_held_level", 32'(bus.level), 32'd2);
                end
                check("bp_queue_depth", 32'(q.size()), 32'd2);
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Steady state at level 1: simultaneous push and pop for 8 cycles.
        bus.out_ready = 1'b0;
        send(vecs[9]);
        bus.out_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(vecs[i]);
            end
            begin
                repeat (8) begin
                    @(negedge clk);
                    check("pushpop_level", 32'(bus.level), 32'd1);
                end
            end
        join
        drain();

        // Asynchronous reset mid-cycle with two entries queued.
        bus.out_ready = 1'b0;
        send(vecs[3]);
        send(vecs[4]);
        check("pre_reset_level", 32'(bus.level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(vecs[6]);
        check("post_reset_level", 32'(bus.level), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
